axi4_lite_mem_system: RTL and testbench



---
 rtl/axi4_lite_mem_system_pkg.sv | 30 +++
 rtl/axi4_lite_if.sv | 52 +++++
 rtl/axi4_lite_mem_system_master.sv | 114 +++++++++++
 rtl/axi4_lite_mem_system_slave.sv | 122 ++++++++++++
 rtl/axi4_lite_mem_system.sv | 46 ++++
 tb/tb_axi4_lite_mem_system.sv | 193 +++++++++++++++++++
 6 files changed

// File: rtl/axi4_lite_mem_system_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_Defs (package)
// Purpose  : Shared widths, response codes and FSM state types for the
//            AXI4-Lite memory subsystem.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_lite_Defs;
    localparam int Addr_Width = 32;
    localparam int Data_Width = 32;
    localparam int MEM_DEPTH  = 4096;
    localparam int MEM_AW     = $clog2(MEM_DEPTH);
    localparam int STRB_W     = Data_Width / 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_ADDR = 2'd1,
        M_RESP = 2'd2
    } master_state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_RESP  = 2'd2
    } slave_state_t;
endpackage
`default_nettype wire

// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_if
// Purpose  : AXI4-Lite five-channel bus bundle with master/slave modports.
//            WSTRB is present only when AXI4_LITE_WSTRB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_if (
    input logic ACLK,
    input logic ARESETN
);
    import axi4_lite_Defs::*;

    logic [Addr_Width-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [Data_Width-1:0] WDATA;
`ifdef AXI4_LITE_WSTRB_EN
    logic [STRB_W-1:0]     WSTRB;
`endif
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [Addr_Width-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [Data_Width-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master_if (
        input  ACLK, ARESETN,
        output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
`ifdef AXI4_LITE_WSTRB_EN
        output WSTRB,
`endif
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave_if (
        input  ACLK, ARESETN,
        input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
`ifdef AXI4_LITE_WSTRB_EN
        input  WSTRB,
`endif
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_mem_system_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_master
// Purpose  : Converts level-style local write/read requests into single
//            AXI4-Lite transactions; independent write and read FSMs.
//            Adds Write_Strobe/WSTRB when AXI4_LITE_WSTRB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_master
    import axi4_lite_Defs::*;
(
    axi4_lite_if.master_if         bus,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [Addr_Width-1:0]  Write_Address,
    input  logic [Addr_Width-1:0]  Read_Address,
    input  logic [Data_Width-1:0]  Write_Data,
`ifdef AXI4_LITE_WSTRB_EN
    input  logic [STRB_W-1:0]      Write_Strobe,
`endif
    output logic [Data_Width-1:0]  rd_data
);
    master_state_t r_wr_state;
    master_state_t r_rd_state;
    logic          w_unused_resp;

    // Responses are always OKAY from the paired slave; nothing consumes them.
    assign w_unused_resp = ^{bus.BRESP, bus.RRESP};

    always_ff @(posedge bus.ACLK or negedge bus.ARESETN) begin
        if (!bus.ARESETN) begin
            r_wr_state  <= M_IDLE;
            bus.AWADDR  <= '0;
            bus.WDATA   <= '0;
`ifdef AXI4_LITE_WSTRB_EN
            bus.WSTRB   <= '0;
`endif
            bus.AWVALID <= 1'b0;
            bus.WVALID  <= 1'b0;
            bus.BREADY  <= 1'b0;
        end else begin
            case (r_wr_state)
                M_IDLE: begin
                    if (wr_en) begin
                        bus.AWADDR  <= Write_Address;
                        bus.WDATA   <= Write_Data;
`ifdef AXI4_LITE_WSTRB_EN
                        bus.WSTRB   <= Write_Strobe;
`endif
                        bus.AWVALID <= 1'b1;
                        bus.WVALID  <= 1'b1;
                        r_wr_state  <= M_ADDR;
                    end
                end
                M_ADDR: begin
                    if (bus.AWVALID && bus.AWREADY && bus.WVALID && bus.WREADY) begin
                        bus.AWVALID <= 1'b0;
                        bus.WVALID  <= 1'b0;
                        bus.BREADY  <= 1'b1;
                        r_wr_state  <= M_RESP;
                    end
                end
                M_RESP: begin
                    if (bus.BVALID && bus.BREADY) begin
                        bus.BREADY <= 1'b0;
                        r_wr_state <= M_IDLE;
                    end
                end
                default: r_wr_state <= M_IDLE;
            endcase
        end
    end

    always_ff @(posedge bus.ACLK or negedge bus.ARESETN) begin
        if (!bus.ARESETN) begin
            r_rd_state  <= M_IDLE;
            bus.ARADDR  <= '0;
            bus.ARVALID <= 1'b0;
            bus.RREADY  <= 1'b0;
        end else begin
            case (r_rd_state)
                M_IDLE: begin
                    if (rd_en) begin
                        bus.ARADDR  <= Read_Address;
                        bus.ARVALID <= 1'b1;
                        r_rd_state  <= M_ADDR;
                    end
                end
                M_ADDR: begin
                    if (bus.ARVALID && bus.ARREADY) begin
                        bus.ARVALID <= 1'b0;
                        bus.RREADY  <= 1'b1;
                        r_rd_state  <= M_RESP;
                    end
                end
                M_RESP: begin
                    if (bus.RVALID && bus.RREADY) begin
                        bus.RREADY <= 1'b0;
                        r_rd_state <= M_IDLE;
                    end
                end
                default: r_rd_state <= M_IDLE;
            endcase
        end
    end

    // Last returned read data survives reset, so it lives outside the reset domain.
    always_ff @(posedge bus.ACLK) begin
        if (r_rd_state == M_RESP && bus.RVALID && bus.RREADY) begin
            rd_data <= bus.RDATA;
        end
    end
endmodule
`default_nettype wire

// File: rtl/axi4_lite_mem_system_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave
// Purpose  : Memory-backed AXI4-Lite slave; word memory 'mem' indexed by
//            address modulo MEM_DEPTH. Byte strobes honoured when
//            AXI4_LITE_WSTRB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_slave
    import axi4_lite_Defs::*;
(
    axi4_lite_if.slave_if bus
);
    slave_state_t          r_wr_state;
    slave_state_t          r_rd_state;
    logic [Data_Width-1:0] mem [MEM_DEPTH];
    logic [MEM_AW-1:0]     w_waddr;
    logic [MEM_AW-1:0]     w_raddr;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic [Data_Width-1:0] w_wr_word;
    logic                  w_unused_addr;

    assign w_waddr       = bus.AWADDR[MEM_AW-1:0];
    assign w_raddr       = bus.ARADDR[MEM_AW-1:0];
    assign w_unused_addr = ^{bus.AWADDR[Addr_Width-1:MEM_AW], bus.ARADDR[Addr_Width-1:MEM_AW]};
    assign w_wr_fire     = (r_wr_state == S_READY) && bus.AWVALID && bus.AWREADY
                           && bus.WVALID && bus.WREADY;
    assign w_rd_fire     = (r_rd_state == S_READY) && bus.ARVALID && bus.ARREADY;

`ifdef AXI4_LITE_WSTRB_EN
    for (genvar b = 0; b < STRB_W; b++) begin : g_lane
        assign w_wr_word[8*b +: 8] = bus.WSTRB[b] ? bus.WDATA[8*b +: 8] : mem[w_waddr][8*b +: 8];
    end
`else
    assign w_wr_word = bus.WDATA;
`endif

    always_ff @(posedge bus.ACLK or negedge bus.ARESETN) begin
        if (!bus.ARESETN) begin
            r_wr_state  <= S_IDLE;
            bus.AWREADY <= 1'b0;
            bus.WREADY  <= 1'b0;
            bus.BVALID  <= 1'b0;
            bus.BRESP   <= OKAY;
        end else begin
            case (r_wr_state)
                S_IDLE: begin
                    if (bus.AWVALID && bus.WVALID) begin
                        bus.AWREADY <= 1'b1;
                        bus.WREADY  <= 1'b1;
                        r_wr_state  <= S_READY;
                    end
                end
                S_READY: begin
                    bus.AWREADY <= 1'b0;
                    bus.WREADY  <= 1'b0;
                    if (w_wr_fire) begin
                        bus.BVALID <= 1'b1;
                        bus.BRESP  <= OKAY;
                        r_wr_state <= S_RESP;
                    end else begin
                        r_wr_state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (bus.BVALID && bus.BREADY) begin
                        bus.BVALID <= 1'b0;
                        r_wr_state <= S_IDLE;
                    end
                end
                default: r_wr_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge bus.ACLK or negedge bus.ARESETN) begin
        if (!bus.ARESETN) begin
            r_rd_state  <= S_IDLE;
            bus.ARREADY <= 1'b0;
            bus.RVALID  <= 1'b0;
            bus.RRESP   <= OKAY;
        end else begin
            case (r_rd_state)
                S_IDLE: begin
                    if (bus.ARVALID) begin
                        bus.ARREADY <= 1'b1;
                        r_rd_state  <= S_READY;
                    end
                end
                S_READY: begin
                    bus.ARREADY <= 1'b0;
                    if (w_rd_fire) begin
                        bus.RVALID <= 1'b1;
                        bus.RRESP  <= OKAY;
                        r_rd_state <= S_RESP;
                    end else begin
                        r_rd_state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (bus.RVALID && bus.RREADY) begin
                        bus.RVALID <= 1'b0;
                        r_rd_state <= S_IDLE;
                    end
                end
                default: r_rd_state <= S_IDLE;
            endcase
        end
    end

    // A read handshaking on the same edge as a write samples the pre-write word.
    always_ff @(posedge bus.ACLK) begin
        if (w_wr_fire) begin
            mem[w_waddr] <= w_wr_word;
        end
        if (w_rd_fire) begin
            bus.RDATA <= mem[w_raddr];
        end
    end
endmodule
`default_nettype wire

// File: rtl/axi4_lite_mem_system.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_mem_system
// Purpose  : AXI4-Lite master + memory slave joined by the bus_observe
//            interface instance. Optional Write_Strobe port under
//            AXI4_LITE_WSTRB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_mem_system
    import axi4_lite_Defs::*;
(
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [Addr_Width-1:0] Read_Address,
    input  logic [Addr_Width-1:0] Write_Address,
    input  logic [Data_Width-1:0] Write_Data,
`ifdef AXI4_LITE_WSTRB_EN
    input  logic [STRB_W-1:0]     Write_Strobe,
`endif
    output logic [Data_Width-1:0] RDATA
);
    axi4_lite_if bus_observe (
        .ACLK    (ACLK),
        .ARESETN (ARESETN)
    );

    axi4_lite_master u_master (
        .bus           (bus_observe),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .Write_Address (Write_Address),
        .Read_Address  (Read_Address),
        .Write_Data    (Write_Data),
`ifdef AXI4_LITE_WSTRB_EN
        .Write_Strobe  (Write_Strobe),
`endif
        .rd_data       (RDATA)
    );

    axi4_lite_slave u_slave (
        .bus (bus_observe)
    );
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_mem_system.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_mem_system
// Purpose  : Directed self-checking bench for axi4_lite_mem_system.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_mem_system;
    logic        ACLK          = 1'b0;
    logic        ARESETN       = 1'b0;
    logic        rd_en         = 1'b0;
    logic        wr_en         = 1'b0;
    logic [31:0] Read_Address  = '0;
    logic [31:0] Write_Address = '0;
    logic [31:0] Write_Data    = '0;
`ifdef AXI4_LITE_WSTRB_EN
    logic [3:0]  Write_Strobe  = 4'hf;
`endif
    logic [31:0] RDATA;
    int          checks   = 0;
    int          failures = 0;

    always #5 ACLK = ~ACLK;

    axi4_lite_mem_system dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .rd_en         (rd_en),
        .wr_en         (wr_en),
        .Read_Address  (Read_Address),
        .Write_Address (Write_Address),
        .Write_Data    (Write_Data),
`ifdef AXI4_LITE_WSTRB_EN
        .Write_Strobe  (Write_Strobe),
`endif
        .RDATA         (RDATA)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".awvalid"}, {31'd0, dut.bus_observe.AWVALID}, 32'd0);
        check({tag, ".wvalid"},  {31'd0, dut.bus_observe.WVALID},  32'd0);
        check({tag, ".awready"}, {31'd0, dut.bus_observe.AWREADY}, 32'd0);
        check({tag, ".wready"},  {31'd0, dut.bus_observe.WREADY},  32'd0);
        check({tag, ".bvalid"},  {31'd0, dut.bus_observe.BVALID},  32'd0);
        check({tag, ".bready"},  {31'd0, dut.bus_observe.BREADY},  32'd0);
        check({tag, ".arvalid"}, {31'd0, dut.bus_observe.ARVALID}, 32'd0);
        check({tag, ".arready"}, {31'd0, dut.bus_observe.ARREADY}, 32'd0);
        check({tag, ".rvalid"},  {31'd0, dut.bus_observe.RVALID},  32'd0);
        check({tag, ".rready"},  {31'd0, dut.bus_observe.RREADY},  32'd0);
    endtask

    // AWVALID after edge0, READYs after edge1, B response after edge2, done after edge3.
    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; Write_Address = a; Write_Data = d;
        tick();
        wr_en = 1'b0;
        check({tag, ".e0.awvalid"}, {31'd0, dut.bus_observe.AWVALID}, 32'd1);
        check({tag, ".e0.wvalid"},  {31'd0, dut.bus_observe.WVALID},  32'd1);
        check({tag, ".e0.awaddr"},  dut.bus_observe.AWADDR, a);
        check({tag, ".e0.wdata"},   dut.bus_observe.WDATA,  d);
        check({tag, ".e0.awready"}, {31'd0, dut.bus_observe.AWREADY}, 32'd0);
        tick();
        check({tag, ".e1.awready"}, {31'd0, dut.bus_observe.AWREADY}, 32'd1);
        check({tag, ".e1.wready"},  {31'd0, dut.bus_observe.WREADY},  32'd1);
        check({tag, ".e1.awvalid"}, {31'd0, dut.bus_observe.AWVALID}, 32'd1);
        check({tag, ".e1.awaddr"},  dut.bus_observe.AWADDR, a);
        tick();
        check({tag, ".e2.awvalid"}, {31'd0, dut.bus_observe.AWVALID}, 32'd0);
        check({tag, ".e2.awready"}, {31'd0, dut.bus_observe.AWREADY}, 32'd0);
        check({tag, ".e2.bvalid"},  {31'd0, dut.bus_observe.BVALID},  32'd1);
        check({tag, ".e2.bready"},  {31'd0, dut.bus_observe.BREADY},  32'd1);
        check({tag, ".e2.bresp"},   {30'd0, dut.bus_observe.BRESP},   32'd0);
        tick();
        check({tag, ".e3.bvalid"},  {31'd0, dut.bus_observe.BVALID},  32'd0);
        check({tag, ".e3.bready"},  {31'd0, dut.bus_observe.BREADY},  32'd0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd_en = 1'b1; Read_Address = a;
        tick();
        rd_en = 1'b0;
        check({tag, ".e0.arvalid"}, {31'd0, dut.bus_observe.ARVALID}, 32'd1);
        check({tag, ".e0.araddr"},  dut.bus_observe.ARADDR, a);
        tick();
        check({tag, ".e1.arready"}, {31'd0, dut.bus_observe.ARREADY}, 32'd1);
        check({tag, ".e1.arvalid"}, {31'd0, dut.bus_observe.ARVALID}, 32'd1);
        check({tag, ".e1.araddr"},  dut.bus_observe.ARADDR, a);
        tick();
        check({tag, ".e2.arvalid"}, {31'd0, dut.bus_observe.ARVALID}, 32'd0);
        check({tag, ".e2.rvalid"},  {31'd0, dut.bus_observe.RVALID},  32'd1);
        check({tag, ".e2.rready"},  {31'd0, dut.bus_observe.RREADY},  32'd1);
        check({tag, ".e2.rdata"},   dut.bus_observe.RDATA, exp);
        check({tag, ".e2.rresp"},   {30'd0, dut.bus_observe.RRESP},   32'd0);
        tick();
        check({tag, ".e3.rvalid"},  {31'd0, dut.bus_observe.RVALID},  32'd0);
        check({tag, ".e3.RDATA"},   RDATA, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two cycles
        tick();
        tick();
        check_idle("reset");
        check("reset.bresp", {30'd0, dut.bus_observe.BRESP}, 32'd0);
        check("reset.rresp", {30'd0, dut.bus_observe.RRESP}, 32'd0);
        ARESETN = 1'b1;
        tick();

        // Basic write then read-after-write
        do_write("wr1", 32'h0000_0abc, 32'h1234_5678);
        check("wr1.mem", dut.u_slave.mem[12'habc], 32'h1234_5678);
        do_read("rd1", 32'h0000_0abc, 32'h1234_5678);

        // Reset before the W handshake: write aborted, memory untouched
        wr_en = 1'b1; Write_Address = 32'h0000_0abc; Write_Data = 32'h5555_5555;
        tick();
        wr_en = 1'b0;
        tick();
        ARESETN = 1'b0;
        #1;
        check_idle("wabort");
        tick();
        check("wabort.mem", dut.u_slave.mem[12'habc], 32'h1234_5678);
        ARESETN = 1'b1;
        tick();

        // Reset mid-read: handshakes clear, last RDATA survives
        rd_en = 1'b1; Read_Address = 32'h0000_0100;
        tick();
        rd_en = 1'b0;
        tick();
        ARESETN = 1'b0;
        #1;
        check_idle("rabort");
        check("rabort.RDATA", RDATA, 32'h1234_5678);
        tick();
        ARESETN = 1'b1;
        tick();

        // Address wraps modulo MEM_DEPTH
        do_write("wrap", 32'h0000_1abc, 32'hdead_beef);
        check("wrap.mem", dut.u_slave.mem[12'habc], 32'hdead_beef);
        do_read("wraprd", 32'h0000_0abc, 32'hdead_beef);

        // Simultaneous write and read of one address: read sees old data
        wr_en = 1'b1; Write_Address = 32'h0000_0abc; Write_Data = 32'hcafe_f00d;
        rd_en = 1'b1; Read_Address  = 32'h0000_0abc;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        check("sim.e1.awready", {31'd0, dut.bus_observe.AWREADY}, 32'd1);
        check("sim.e1.arready", {31'd0, dut.bus_observe.ARREADY}, 32'd1);
        tick();
        check("sim.e2.rdata", dut.bus_observe.RDATA, 32'hdead_beef);
        check("sim.e2.mem",   dut.u_slave.mem[12'habc], 32'hcafe_f00d);
        tick();
        check("sim.e3.RDATA", RDATA, 32'hdead_beef);
        do_read("simrd", 32'h0000_0abc, 32'hcafe_f00d);

`ifdef AXI4_LITE_WSTRB_EN
        // Byte strobes update only the selected lanes
        Write_Strobe = 4'hf;
        do_write("strb0", 32'h0000_0020, 32'h1234_5678);
        Write_Strobe = 4'b0011;
        do_write("strb1", 32'h0000_0020, 32'hffff_ffff);
        check("strb.mem", dut.u_slave.mem[12'h020], 32'h1234_ffff);
        do_read("strbrd", 32'h0000_0020, 32'h1234_ffff);
        Write_Strobe = 4'hf;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
